// File: rtl/shift_rotate_unit.sv
// Iterative shift/rotate unit: SHR, SHRA, SHL, ROR, ROL over WIDTH bits, moving up to STEP positions per cycle.
// Latency: ceil(shamt/STEP) RUN cycles, then one DONE cycle. Zero amounts and illegal ops go straight to DONE.
// Backpressure: none. A start that arrives while busy is dropped, not queued. The caller waits for done.
//
// Ports:
//   clk, clr         clock and synchronous active-high clear
//   start            request pulse, sampled only in IDLE
//   op               000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101-111 pass-through (flagged illegal)
//   operand_a        value to shift
//   shamt            shift amount, implicitly modulo WIDTH
//   busy             high in RUN and DONE
//   done             one-cycle pulse; result/carry_out valid from this cycle
//   result           shifted value, held until the next accepted operation's DONE cycle
//   carry_out        last bit shifted or rotated out
//   illegal_op       set at acceptance of a 101-111 opcode, cleared by the next accepted start
module shift_rotate_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             illegal_op
);

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    // STEP can equal WIDTH, which does not fit in SHW bits, so keep one extra bit for the comparison.
    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   rem;
    logic [2:0]       opcode;

    logic             op_illegal;
    logic             rem_lt_step;
    logic             last_step;
    logic [SHW-1:0]   k;

    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] ror_dbl;
    logic [2*WIDTH-1:0] rol_dbl;
    logic [WIDTH-1:0]   ror_val;
    logic [WIDTH-1:0]   rol_val;
    logic [WIDTH-1:0]   shr_val;
    logic [WIDTH-1:0]   shl_val;
    logic [WIDTH-1:0]   shra_val;
    logic signed [WIDTH-1:0] acc_s;

    logic [WIDTH-1:0] acc_step;
    logic             carry_step;

    assign op_illegal  = (op > OP_ROL);

    // k = min(STEP, rem). When rem >= STEP, STEP < WIDTH, so truncating STEP_W to SHW bits is exact.
    assign rem_lt_step = ({1'b0, rem} < STEP_W);
    assign last_step   = ({1'b0, rem} <= STEP_W);
    assign k           = rem_lt_step ? rem : STEP_W[SHW-1:0];

    // Rotates come from a doubled copy of acc, so no (WIDTH - k) term is needed.
    assign dbl      = {acc, acc};
    assign ror_dbl  = dbl >> k;
    assign rol_dbl  = dbl << k;
    assign ror_val  = ror_dbl[WIDTH-1:0];
    assign rol_val  = rol_dbl[2*WIDTH-1:WIDTH];
    assign shr_val  = acc >> k;
    assign shl_val  = acc << k;
    assign acc_s    = acc;
    assign shra_val = acc_s >>> k;

    // The bit that leaves on the right, acc[k-1], lands in the rotate-right MSB.
    // The bit that leaves on the left, acc[WIDTH-k], lands in the rotate-left LSB.
    // Reusing those taps avoids variable-index subtraction.
    always_comb begin
        acc_step   = acc;
        carry_step = carry_out;
        case (opcode)
            OP_SHR: begin
                acc_step   = shr_val;
                carry_step = ror_val[WIDTH-1];
            end
            OP_SHRA: begin
                acc_step   = shra_val;
                carry_step = ror_val[WIDTH-1];
            end
            OP_SHL: begin
                acc_step   = shl_val;
                carry_step = rol_val[0];
            end
            OP_ROR: begin
                acc_step   = ror_val;
                carry_step = ror_val[WIDTH-1];
            end
            OP_ROL: begin
                acc_step   = rol_val;
                carry_step = rol_val[0];
            end
            default: begin
                acc_step   = acc;
                carry_step = carry_out;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((shamt == '0) || op_illegal) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // result is loaded on the edge that enters DONE, so it already equals the final acc
    // during the done cycle rather than one cycle later.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc        <= '0;
            rem        <= '0;
            opcode     <= '0;
            result     <= '0;
            carry_out  <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= operand_a;
                        rem        <= shamt;
                        opcode     <= op;
                        carry_out  <= 1'b0;
                        illegal_op <= op_illegal;
                        if ((shamt == '0) || op_illegal) begin
                            result <= operand_a;
                        end
                    end
                end
                RUN: begin
                    acc       <= acc_step;
                    rem       <= rem - k;
                    carry_out <= carry_step;
                    if (last_step) begin
                        result <= acc_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

endmodule
